// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: condition codes, FIFO occupancy
// states and the buffered-entry layout.
`timescale 1ns/1ps
package alu_pkg;

    localparam int WB_WIDTH   = 3;
    localparam int WB_RD_BITS = 4;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_MI = 3'b011,
        COND_PL = 3'b100,
        COND_CS = 3'b101,
        COND_VS = 3'b110,
        COND_NV = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_WIDTH:0]     result;
        logic [WB_RD_BITS-1:0] rd;
        logic                  we;
    } wb_entry_t;

    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_cond_eval.sv
// Combinational condition-code check against the architectural NZCV flags.
`timescale 1ns/1ps
module cond_eval
    import alu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flagN,
    input  logic       flagZ,
    input  logic       flagC,
    input  logic       flagV,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = flagZ;
            COND_NE: pass = !flagZ;
            COND_MI: pass = flagN;
            COND_PL: pass = !flagN;
            COND_CS: pass = flagC;
            COND_VS: pass = flagV;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: status-flag register, per-op condition check and a
// 2-entry skid FIFO in front of the register-file write port.
`timescale 1ns/1ps
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = WB_WIDTH,
    parameter int RD_BITS = WB_RD_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH:0]     in_result,
    input  logic               in_negativo,
    input  logic               in_cero,
    input  logic               in_acarreo,
    input  logic               in_desbordamiento,
    input  logic               in_set_flags,
    input  logic [2:0]         in_cond,
    input  logic [RD_BITS-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_result,
    output logic [RD_BITS-1:0] out_rd,
    output logic               out_we,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v,
    output logic [7:0]         suppressed_cnt
);

    // The buffered-entry struct lives in the package at the default widths.
    if (WIDTH != WB_WIDTH || RD_BITS != WB_RD_BITS) begin : gWidthGuard
        $error("alu_writeback_stage: WIDTH/RD_BITS must match alu_pkg entry widths");
    end

    wb_state_e state;
    wb_entry_t headEntry;
    wb_entry_t tailEntry;
    wb_entry_t newEntry;
    logic      condPass;
    logic      accept;
    logic      pop;

    cond_eval uCondEval (
        .cond  (in_cond),
        .flagN (flag_n),
        .flagZ (flag_z),
        .flagC (flag_c),
        .flagV (flag_v),
        .pass  (condPass)
    );

    assign in_ready  = (state != TWO) && !flush;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign newEntry = '{result: in_result, rd: in_rd, we: condPass};

    assign out_result = headEntry.result;
    assign out_rd     = headEntry.rd;
    assign out_we     = headEntry.we && out_valid;

    // Head register feeds the outputs directly; tail only fills while head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            headEntry <= '0;
            tailEntry <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        headEntry <= newEntry;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            tailEntry <= newEntry;
                            state     <= TWO;
                        end
                        2'b01: state <= EMPTY;
                        2'b11: headEntry <= newEntry;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (pop) begin
                        headEntry <= tailEntry;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Flags update only on a passing accept, so the next op's condition sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n         <= 1'b0;
            flag_z         <= 1'b0;
            flag_c         <= 1'b0;
            flag_v         <= 1'b0;
            suppressed_cnt <= 8'd0;
        end else if (accept) begin
            if (condPass && in_set_flags) begin
                flag_n <= in_negativo;
                flag_z <= in_cero;
                flag_c <= in_acarreo;
                flag_v <= in_desbordamiento;
            end
            if (!condPass) begin
                suppressed_cnt <= satInc8(suppressed_cnt);
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomized and directed bench for alu_writeback_stage against a queue-based
// reference model of the FIFO, status flags and suppression counter.
`timescale 1ns/1ps
module tb_alu_writeback_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_negativo, in_cero, in_acarreo, in_desbordamiento;
    logic       in_set_flags;
    logic [2:0] in_cond;
    logic [3:0] in_rd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_rd;
    logic       out_we;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic [7:0] suppressed_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] res;
        logic [3:0] rd;
        logic       we;
    } mEntry_t;

    mEntry_t    mq[$];
    logic [3:0] mFlags;   // {N,Z,C,V}
    int         mCnt;

    always #5 clk = ~clk;

    alu_writeback_stage #(.WIDTH(3), .RD_BITS(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_result         (in_result),
        .in_negativo       (in_negativo),
        .in_cero           (in_cero),
        .in_acarreo        (in_acarreo),
        .in_desbordamiento (in_desbordamiento),
        .in_set_flags      (in_set_flags),
        .in_cond           (in_cond),
        .in_rd             (in_rd),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_rd            (out_rd),
        .out_we            (out_we),
        .flag_n            (flag_n),
        .flag_z            (flag_z),
        .flag_c            (flag_c),
        .flag_v            (flag_v),
        .suppressed_cnt    (suppressed_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic modelPass(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[2];
            3'd2: return !f[2];
            3'd3: return f[3];
            3'd4: return !f[3];
            3'd5: return f[1];
            3'd6: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic compareAll();
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_result", out_result, mq[0].res);
            chk("out_rd", out_rd, mq[0].rd);
            chk("out_we", out_we, mq[0].we);
        end
        chk("flags", {flag_n, flag_z, flag_c, flag_v}, mFlags);
        chk("suppressed_cnt", suppressed_cnt, mCnt);
    endtask

    task automatic modelReset();
        mq.delete();
        mFlags = 4'b0000;
        mCnt   = 0;
    endtask

    // One clock: check outputs, drive inputs, then advance the model to the next edge.
    task automatic cycle(input logic v, input logic [3:0] res, input logic [3:0] rd,
                         input logic [3:0] nzcv, input logic sf, input logic [2:0] cond,
                         input logic ordy, input logic fl);
        logic   acc, pp, ps;
        mEntry_t e;
        @(negedge clk);
        compareAll();
        in_valid     = v;
        in_result    = res;
        in_rd        = rd;
        {in_negativo, in_cero, in_acarreo, in_desbordamiento} = nzcv;
        in_set_flags = sf;
        in_cond      = cond;
        out_ready    = ordy;
        flush        = fl;
        #1;
        chk("in_ready", in_ready, (mq.size() < 2) && !fl);
        acc = v && (mq.size() < 2) && !fl;
        pp  = (mq.size() != 0) && ordy && !fl;
        ps  = modelPass(cond, mFlags);
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                e.res = res; e.rd = rd; e.we = ps;
                mq.push_back(e);
            end
        end
        if (acc && ps && sf) mFlags = nzcv;
        if (acc && !ps && mCnt < 255) mCnt++;
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 3'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {flush, in_valid, in_result, in_negativo, in_cero, in_acarreo, in_desbordamiento} = '0;
        {in_set_flags, in_cond, in_rd, out_ready} = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("lit_reset_out_valid", out_valid, 1'b0);
        chk("lit_reset_in_ready", in_ready, 1'b1);
        chk("lit_reset_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
        chk("lit_reset_cnt", suppressed_cnt, 8'd0);

        // pass-through
        cycle(1'b1, 4'b0101, 4'd3, 4'b1000, 1'b1, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_pt_valid", out_valid, 1'b1);
        chk("lit_pt_result", out_result, 4'd5);
        chk("lit_pt_rd", out_rd, 4'd3);
        chk("lit_pt_we", out_we, 1'b1);
        chk("lit_pt_n", flag_n, 1'b1);
        chk("lit_pt_z", flag_z, 1'b0);

        // forwarding, EQ passes on flags written by the op just before
        cycle(1'b1, 4'd9, 4'd1, 4'b0100, 1'b1, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_eqA_we", out_we, 1'b1);
        cycle(1'b1, 4'd6, 4'd2, 4'b0000, 1'b0, 3'b001, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_eqB_result", out_result, 4'd6);
        chk("lit_eqB_we", out_we, 1'b1);

        // forwarding, NE fails and leaves flags alone
        cycle(1'b1, 4'd7, 4'd4, 4'b0100, 1'b1, 3'b000, 1'b1, 1'b0);
        cycle(1'b1, 4'd8, 4'd5, 4'b1011, 1'b1, 3'b010, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_neB_result", out_result, 4'd8);
        chk("lit_neB_we", out_we, 1'b0);
        chk("lit_neB_cnt", suppressed_cnt, 8'd1);
        chk("lit_neB_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0100);
        repeat (2) cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000, 1'b1, 1'b0);

        // backpressure
        cycle(1'b1, 4'd1, 4'd1, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 4'd2, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("lit_bp_in_ready", in_ready, 1'b0);
        cycle(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_bp_head2", out_result, 4'd2);
        cycle(1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_bp_head3", out_result, 4'd3);

        // flush with two entries buffered and a simultaneous input
        cycle(1'b1, 4'd10, 4'd6, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 4'd11, 4'd7, 4'b1111, 1'b1, 3'b000, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("lit_flush_valid", out_valid, 1'b0);
        chk("lit_flush_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0100);
        chk("lit_flush_cnt", suppressed_cnt, 8'd1);
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_flush_noaccept", out_valid, 1'b0);

        // saturation of the suppression counter
        for (int i = 0; i < 260; i++)
            cycle(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'b111, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("lit_sat_cnt", suppressed_cnt, 8'd255);

        randomCycles(400);

        // asynchronous reset mid-stream
        cycle(1'b1, 4'd12, 4'd9, 4'b1010, 1'b1, 3'b000, 1'b0, 1'b0);
        cycle(1'b1, 4'd13, 4'd8, 4'b0101, 1'b1, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_valid", out_valid, 1'b0);
        chk("lit_arst_we", out_we, 1'b0);
        chk("lit_arst_result", out_result, 4'd0);
        chk("lit_arst_rd", out_rd, 4'd0);
        chk("lit_arst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
        chk("lit_arst_cnt", suppressed_cnt, 8'd0);
        chk("lit_arst_in_ready", in_ready, 1'b1);
        modelReset();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        randomCycles(150);
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        compareAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Sits directly downstream of the ALU result/flag mux and captures each ALU result together with its four flags (negativo, cero, acarreo, desbordamiento).
- Holds the architectural status-flag register and evaluates a per-operation condition code against it.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes so the register-file write port can stall without losing ALU output.

Parameters:
- WIDTH, 3, MSB index of the data path; data is WIDTH+1 bits, matching the ALU.
- RD_BITS, 4, width of the destination-register index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous clear of buffered entries; flags are untouched.
- in_valid  input  1  ALU output valid.
- in_ready  output  1  stage can accept; equals (count != 2) && !flush.
- in_result  input  WIDTH+1  ALU result.
- in_negativo, in_cero, in_acarreo, in_desbordamiento  input  1 each  ALU flags.
- in_set_flags  input  1  update the status register if the condition passes.
- in_cond  input  3  condition code, evaluated before this op's own flag update.
- in_rd  input  RD_BITS  destination register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  WIDTH+1  head result.
- out_rd  output  RD_BITS  head destination.
- out_we  output  1  head condition passed; the register file writes only when this is 1.
- flag_n, flag_z, flag_c, flag_v  output  1 each  status register.
- suppressed_cnt  output  8  count of condition-failed ops; saturates at 255.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0 (state EMPTY), out_valid=0, out_we=0.
  - out_result=0, out_rd=0.
  - All flags=0, suppressed_cnt=0.
  - Reset mid-operation discards every buffered entry.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- FSM states are EMPTY, ONE, TWO. Transitions:
  - EMPTY: accept goes to ONE.
  - ONE: accept without pop goes to TWO; pop without accept goes to EMPTY; accept and pop together stay in ONE.
  - TWO: pop goes to ONE. Accept cannot occur because in_ready=0.
- Latency: an entry accepted at edge N shows out_valid=1 after edge N (1 cycle) when the buffer is empty.
- Ordering: FIFO order is strictly preserved, and out_* are driven from registers.
- Condition pass is computed from the current flag register (pre-update value). Codes:
  - 000 always.
  - 001 Z=1; 010 Z=0.
  - 011 N=1; 100 N=0.
  - 101 C=1.
  - 110 V=1.
  - 111 never.
- On accept:
  - The stored entry's we = pass.
  - If pass && in_set_flags, the flags load from the in_* flags at the same edge.
  - If !pass, suppressed_cnt increments, saturating at 255. The entry is still queued with we=0 so ordering and retire accounting are preserved.
- Back-to-back accepts: the second op's condition sees the flags written by the first (single-cycle forwarding through the register).
- flush:
  - Next edge sets count=0 and out_valid=0.
  - in_ready=0 during flush, so no accept occurs that cycle.
  - A pop during flush is ignored.
  - Flags and suppressed_cnt are retained.
- Width rule: results pass through unmodified; there is no sign extension.

Decomposition:
- Shared package alu_pkg holds:
  - the cond_e enum (COND_AL, COND_EQ, COND_NE, COND_MI, COND_PL, COND_CS, COND_VS, COND_NV);
  - the wb_state_e enum (EMPTY, ONE, TWO);
  - a packed struct wb_entry_t {result, rd, we}.
- One natural sub-module, cond_eval: combinational, takes cond and the NZCV flags and outputs pass.
- The FIFO and FSM stay in the top module.

Test Plan:
- Reset then idle: after rst_n deasserts, out_valid=0, in_ready=1, flags=0000, suppressed_cnt=0.
- Pass-through: accept result=4'b0101, rd=3, cond=000, set_flags=1, cero=0, negativo=1 with out_ready=1. Next cycle: out_valid=1, out_result=5, out_rd=3, out_we=1, flag_n=1, flag_z=0.
- Condition forwarding:
  - op A: cero=1, set_flags=1; op B back-to-back: cond=001 (EQ). Expected: out_we=1 for both.
  - Repeat with cond=010 (NE) on op B. Expected: B out_we=0, suppressed_cnt=1, flags unchanged by B.
- Backpressure: out_ready=0 with three consecutive valid ops. Expected: first two accepted, in_ready=0 on the third. Then raise out_ready: entries drain in order and the third is accepted once count drops to 1.
- Flush and reset mid-operation:
  - Two entries buffered, pulse flush together with in_valid=1. Expected: out_valid=0 next cycle, the input is not accepted, flags retained.
  - Assert rst_n=0 asynchronously mid-stream. Expected: all outputs return to reset values immediately.
